// File: rtl/tb_douta_router_pkg.sv
// Shared encodings and the select bundle carried down the router's alignment delay line.
package tb_douta_router_pkg;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b10;
    localparam logic [1:0] DIR_NEW  = 2'b11;

    localparam int DST_A = 0;
    localparam int DST_M = 1;

    // The delay line always stores wide fields so out-of-range indices survive to the error check.
    localparam int SEL_DST_W = 8;
    localparam int SEL_OFS_W = 8;

    typedef struct packed {
        logic                 vld;
        logic [SEL_DST_W-1:0] dst;
        logic [1:0]           dir;
        logic [SEL_OFS_W-1:0] ofs;
    } sel_bundle_t;

endpackage

// File: rtl/tb_douta_router_if.sv
// Select/data bundle between the TB controller and BRAM read port (master) and the router (slave).
interface tb_douta_router_if #(
    parameter int X      = 4,
    parameter int L      = 4,
    parameter int RSA_DW = 32,
    parameter int NDST   = 2,
    parameter int DST_W  = (NDST > 1) ? $clog2(NDST) : 1,
    parameter int OFS_W  = 1
);
    logic                       sel_vld;
    logic [DST_W-1:0]           sel_dst;
    logic [1:0]                 sel_dir;
    logic [OFS_W-1:0]           sel_ofs;
    logic [L*RSA_DW-1:0]        TB_douta;
    logic [NDST*X*RSA_DW-1:0]   dst_douta;
    logic [NDST-1:0]            dst_vld;
    logic                       map_err;

    modport master (
        output sel_vld, sel_dst, sel_dir, sel_ofs, TB_douta,
        input  dst_douta, dst_vld, map_err
    );

    modport slave (
        input  sel_vld, sel_dst, sel_dir, sel_ofs, TB_douta,
        output dst_douta, dst_vld, map_err
    );

endinterface

// File: rtl/tb_lane_map.sv
// Combinational L-lane to X-lane mapper: idle, direct, reversed, or a WIN-lane window at offset ofs.
module tb_lane_map
    import tb_douta_router_pkg::*;
#(
    parameter int X      = 4,
    parameter int L      = 4,
    parameter int RSA_DW = 32,
    parameter int WIN    = 2,
    parameter int OFS_W  = 1
) (
    input  logic [1:0]          dir,
    input  logic [OFS_W-1:0]    ofs,
    input  logic [L*RSA_DW-1:0] lanes_in,
    output logic [X*RSA_DW-1:0] lanes_out
);
    localparam int NWIN = L / WIN;

    for (genvar i = 0; i < X; i++) begin : g_lane
        logic [RSA_DW-1:0] pos_l;
        logic [RSA_DW-1:0] neg_l;
        logic [RSA_DW-1:0] new_l;

        if (i < L) begin : g_pos
            assign pos_l = lanes_in[i*RSA_DW +: RSA_DW];
        end else begin : g_pos_zero
            assign pos_l = '0;
        end

        if (X - 1 - i < L) begin : g_neg
            assign neg_l = lanes_in[(X-1-i)*RSA_DW +: RSA_DW];
        end else begin : g_neg_zero
            assign neg_l = '0;
        end

        // OR-chain mux over every window; an offset past the last window selects nothing.
        if (i < WIN) begin : g_win
            logic [NWIN:0][RSA_DW-1:0] acc;
            assign acc[0] = '0;
            for (genvar w = 0; w < NWIN; w++) begin : g_cand
                assign acc[w+1] = acc[w] |
                    ((ofs == OFS_W'(w)) ? lanes_in[(w*WIN+i)*RSA_DW +: RSA_DW] : '0);
            end
            assign new_l = acc[NWIN];
        end else begin : g_win_zero
            assign new_l = '0;
        end

        assign lanes_out[i*RSA_DW +: RSA_DW] = (dir == DIR_POS) ? pos_l :
                                               (dir == DIR_NEG) ? neg_l :
                                               (dir == DIR_NEW) ? new_l : '0;
    end

endmodule

// File: rtl/tb_douta_router.sv
// Routes the TB BRAM port-A read word to one of NDST systolic-array operand ports.
// Optional macro TB_ROUTER_HOLD_EN adds a hold input that freezes the whole pipeline.
module tb_douta_router
    import tb_douta_router_pkg::*;
#(
    parameter int X      = 4,
    parameter int L      = 4,
    parameter int RSA_DW = 32,
    parameter int NDST   = 2,
    parameter int RD_LAT = 1,
    parameter int WIN    = 2
) (
    input  logic clk,
    input  logic sys_rst_n,
`ifdef TB_ROUTER_HOLD_EN
    input  logic hold,
`endif
    tb_douta_router_if.slave bus
);
    localparam int NWIN      = L / WIN;
    localparam int OFS_W     = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int LANE_BITS = X * RSA_DW;
    localparam logic [SEL_DST_W-1:0] NDST_C = SEL_DST_W'(NDST);
    localparam logic [SEL_OFS_W-1:0] NWIN_C = SEL_OFS_W'(NWIN);

    if ((L % WIN) != 0 || WIN > X) begin : g_bad_win
        $error("tb_douta_router: WIN must divide L and be no larger than X");
    end
    if (RD_LAT < 1) begin : g_bad_lat
        $error("tb_douta_router: RD_LAT must be at least 1");
    end

    logic advance;
`ifdef TB_ROUTER_HOLD_EN
    assign advance = ~hold;
`else
    assign advance = 1'b1;
`endif

    sel_bundle_t                  sel_in;
    sel_bundle_t [RD_LAT-1:0]     pipe;
    sel_bundle_t [RD_LAT:0]       taps;
    sel_bundle_t                  aligned;

    assign sel_in.vld = bus.sel_vld;
    assign sel_in.dst = SEL_DST_W'(bus.sel_dst);
    assign sel_in.dir = bus.sel_dir;
    assign sel_in.ofs = SEL_OFS_W'(bus.sel_ofs);

    // taps[k] feeds stage k, so the shift needs no special case for RD_LAT == 1.
    assign taps    = {pipe, sel_in};
    assign aligned = pipe[RD_LAT-1];

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pipe <= '0;
        end else if (advance) begin
            pipe <= taps[RD_LAT-1:0];
        end
    end

    logic [LANE_BITS-1:0] mapped;

    tb_lane_map #(
        .X      (X),
        .L      (L),
        .RSA_DW (RSA_DW),
        .WIN    (WIN),
        .OFS_W  (OFS_W)
    ) u_lane_map (
        .dir       (aligned.dir),
        .ofs       (aligned.ofs[OFS_W-1:0]),
        .lanes_in  (bus.TB_douta),
        .lanes_out (mapped)
    );

    logic err;
    logic fire;

    assign err  = aligned.vld &&
                  ((aligned.dst >= NDST_C) || (aligned.dir == DIR_NEW && aligned.ofs >= NWIN_C));
    assign fire = aligned.vld && (aligned.dir != DIR_IDLE) && !err;

    logic [NDST-1:0][LANE_BITS-1:0] data_d;
    logic [NDST-1:0][LANE_BITS-1:0] data_q;
    logic [NDST-1:0]                vld_d;
    logic [NDST-1:0]                vld_q;
    logic                           map_err_q;

    // Unselected ports are driven to zero every cycle; the array depends on zero operands.
    for (genvar d = 0; d < NDST; d++) begin : g_dst
        logic hit;
        assign hit       = fire && (aligned.dst == SEL_DST_W'(d));
        assign vld_d[d]  = hit;
        assign data_d[d] = hit ? mapped : '0;
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_q    <= '0;
            vld_q     <= '0;
            map_err_q <= 1'b0;
        end else if (advance) begin
            data_q <= data_d;
            vld_q  <= vld_d;
            if (err) begin
                map_err_q <= 1'b1;
            end
        end
    end

    assign bus.dst_douta = data_q;
    assign bus.dst_vld   = vld_q;
    assign bus.map_err   = map_err_q;

endmodule

// File: tb/tb_tb_douta_router.sv
// Directed bench for tb_douta_router: one 3-port RD_LAT=1 instance and one 6-lane RD_LAT=3 instance.
module tb_tb_douta_router;
    import tb_douta_router_pkg::*;

    logic clk = 1'b0;
    logic sys_rst_n;
`ifdef TB_ROUTER_HOLD_EN
    logic hold;
    logic [2:0] hold_exp [5];
    int         hold_dst [5];
    int         beat;
    int         got;
    logic       held_prev;
    logic [2:0] last_vld;
`endif

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    localparam logic [127:0] W_POS  = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] W_NEG  = {32'd1, 32'd2, 32'd3, 32'd4};
    localparam logic [127:0] W_NEW0 = {64'd0, 32'd2, 32'd1};
    localparam logic [127:0] W_NEW1 = {64'd0, 32'd4, 32'd3};
    localparam logic [127:0] W_NEWB = {64'd0, 32'd6, 32'd5};

    tb_douta_router_if #(.X(4), .L(4), .RSA_DW(32), .NDST(3), .DST_W(2), .OFS_W(1)) ia ();
    tb_douta_router_if #(.X(4), .L(6), .RSA_DW(32), .NDST(2), .DST_W(1), .OFS_W(2)) ib ();

    tb_douta_router #(.X(4), .L(4), .RSA_DW(32), .NDST(3), .RD_LAT(1), .WIN(2)) dut_a (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
`ifdef TB_ROUTER_HOLD_EN
        .hold      (hold),
`endif
        .bus       (ia.slave)
    );

    tb_douta_router #(.X(4), .L(6), .RSA_DW(32), .NDST(2), .RD_LAT(3), .WIN(2)) dut_b (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
`ifdef TB_ROUTER_HOLD_EN
        .hold      (hold),
`endif
        .bus       (ib.slave)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [2:0] v,
                           input logic [127:0] a, input logic [127:0] m, input logic [127:0] e);
        check({tag, ".vld"}, 128'(ia.dst_vld), 128'(v));
        check({tag, ".A"}, ia.dst_douta[127:0], a);
        check({tag, ".M"}, ia.dst_douta[255:128], m);
        check({tag, ".X2"}, ia.dst_douta[383:256], e);
    endtask

    task automatic check_b(input string tag, input logic [1:0] v,
                           input logic [127:0] a, input logic [127:0] m);
        check({tag, ".vld"}, 128'(ib.dst_vld), 128'(v));
        check({tag, ".A"}, ib.dst_douta[127:0], a);
        check({tag, ".M"}, ib.dst_douta[255:128], m);
    endtask

    task automatic sel_a(input logic v, input logic [1:0] d, input logic [1:0] dir, input logic o);
        ia.sel_vld = v;
        ia.sel_dst = d;
        ia.sel_dir = dir;
        ia.sel_ofs = o;
    endtask

    task automatic sel_b(input logic v, input logic d, input logic [1:0] dir, input logic [1:0] o);
        ib.sel_vld = v;
        ib.sel_dst = d;
        ib.sel_dir = dir;
        ib.sel_ofs = o;
    endtask

    // Issue one select on instance B and wait out its four-cycle select-to-valid latency.
    task automatic beat_b(input logic d, input logic [1:0] dir, input logic [1:0] o);
        sel_b(1'b1, d, dir, o);
        @(negedge clk);
        sel_b(1'b0, 1'b0, DIR_IDLE, 2'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        sys_rst_n = 1'b0;
`ifdef TB_ROUTER_HOLD_EN
        hold = 1'b0;
`endif
        sel_a(1'b0, 2'd0, DIR_IDLE, 1'b0);
        sel_b(1'b0, 1'b0, DIR_IDLE, 2'd0);
        ia.TB_douta = W_POS;
        ib.TB_douta = {32'd6, 32'd5, W_POS};
        #3;
        check_a("reset_a", 3'b000, '0, '0, '0);
        check("reset_a.err", 128'(ia.map_err), 128'(0));
        check_b("reset_b", 2'b00, '0, '0);
        check("reset_b.err", 128'(ib.map_err), 128'(0));
        repeat (2) @(negedge clk);
        sys_rst_n = 1'b1;
        @(negedge clk);

        sel_a(1'b1, 2'(DST_A), DIR_POS, 1'b0);
        @(negedge clk);
        sel_a(1'b0, 2'd0, DIR_IDLE, 1'b0);
        check_a("pos.early", 3'b000, '0, '0, '0);
        @(negedge clk);
        check_a("pos", 3'b001, W_POS, '0, '0);

        sel_a(1'b1, 2'(DST_M), DIR_NEG, 1'b0);
        @(negedge clk);
        sel_a(1'b0, 2'd0, DIR_IDLE, 1'b0);
        @(negedge clk);
        check_a("neg", 3'b010, '0, W_NEG, '0);

        sel_a(1'b1, 2'd0, DIR_NEW, 1'b0);
        @(negedge clk);
        sel_a(1'b1, 2'd0, DIR_NEW, 1'b1);
        @(negedge clk);
        sel_a(1'b0, 2'd0, DIR_IDLE, 1'b0);
        check_a("new.ofs0", 3'b001, W_NEW0, '0, '0);
        @(negedge clk);
        check_a("new.ofs1", 3'b001, W_NEW1, '0, '0);
        @(negedge clk);
        check_a("new.drain", 3'b000, '0, '0, '0);

        sel_a(1'b1, 2'd1, DIR_IDLE, 1'b0);
        @(negedge clk);
        sel_a(1'b0, 2'd0, DIR_IDLE, 1'b0);
        @(negedge clk);
        check_a("idle", 3'b000, '0, '0, '0);

        sel_a(1'b1, 2'd2, DIR_POS, 1'b0);
        @(negedge clk);
        sel_a(1'b0, 2'd0, DIR_IDLE, 1'b0);
        @(negedge clk);
        check_a("dst2", 3'b100, '0, '0, W_POS);
        check("dst2.err", 128'(ia.map_err), 128'(0));

        sel_a(1'b1, 2'd3, DIR_POS, 1'b0);
        @(negedge clk);
        sel_a(1'b0, 2'd0, DIR_IDLE, 1'b0);
        @(negedge clk);
        check_a("bad_dst", 3'b000, '0, '0, '0);
        check("bad_dst.err", 128'(ia.map_err), 128'(1));

        sel_a(1'b1, 2'd0, DIR_NEG, 1'b0);
        @(negedge clk);
        sel_a(1'b0, 2'd0, DIR_IDLE, 1'b0);
        @(negedge clk);
        check_a("after_err", 3'b001, W_NEG, '0, '0);
        check("after_err.sticky", 128'(ia.map_err), 128'(1));

        // Stream POS beats and pull reset between clock edges while the pipeline is full.
        sel_a(1'b1, 2'd0, DIR_POS, 1'b0);
        repeat (2) @(negedge clk);
        check("stream.vld", 128'(ia.dst_vld), 128'(3'b001));
        @(posedge clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check_a("midrst", 3'b000, '0, '0, '0);
        check("midrst.err", 128'(ia.map_err), 128'(0));
        repeat (2) @(negedge clk);
        sel_a(1'b0, 2'd0, DIR_IDLE, 1'b0);
        sys_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst.vld", 128'(ia.dst_vld), 128'(0));
        end

        sel_b(1'b1, 1'b0, DIR_POS, 2'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sel_b(1'b0, 1'b0, DIR_IDLE, 2'd0);
            check("lat3.early", 128'(ib.dst_vld), 128'(0));
        end
        @(negedge clk);
        check_b("lat3.pos", 2'b01, W_POS, '0);

        beat_b(1'b1, DIR_NEG, 2'd0);
        check_b("lat3.neg", 2'b10, '0, W_NEG);

        beat_b(1'b0, DIR_NEW, 2'd2);
        check_b("lat3.new2", 2'b01, W_NEWB, '0);
        check("lat3.new2.err", 128'(ib.map_err), 128'(0));

        beat_b(1'b0, DIR_NEW, 2'd3);
        check_b("lat3.bad_ofs", 2'b00, '0, '0);
        check("lat3.bad_ofs.err", 128'(ib.map_err), 128'(1));

`ifdef TB_ROUTER_HOLD_EN
        // Five beats with a three-cycle hold in the middle: each beat must emerge exactly once.
        hold_dst  = '{0, 1, 2, 0, 1};
        hold_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        beat      = 0;
        got       = 0;
        held_prev = 1'b0;
        last_vld  = 3'b000;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) begin
                if (held_prev) begin
                    check("hold.freeze", 128'(ia.dst_vld), 128'(last_vld));
                end else if (ia.dst_vld != 3'b000) begin
                    if (got < 5) begin
                        check("hold.order", 128'(ia.dst_vld), 128'(hold_exp[got]));
                    end
                    got++;
                end
            end
            last_vld = ia.dst_vld;
            hold = (c >= 3 && c < 6);
            if (!hold) begin
                if (beat < 5) begin
                    sel_a(1'b1, 2'(hold_dst[beat]), DIR_POS, 1'b0);
                    beat++;
                end else begin
                    sel_a(1'b0, 2'd0, DIR_IDLE, 1'b0);
                end
            end
            held_prev = hold;
            @(negedge clk);
        end
        hold = 1'b0;
        check("hold.count", 128'(got), 128'(5));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tb_douta_router.md
Name: tb_douta_router

Overview:
Parametrised successor to the two-destination TB port-A read-data mapper.
- Routes the L-lane TB BRAM read word to one of NDST systolic-array input ports, each X lanes wide.
- Supports four lane maps: idle, direct, reversed, and windowed extract with a run-time window offset.
- Carries the select through an internal delay line of RD_LAT stages, so the controller issues the select in the same cycle as the BRAM address. Data and select then align without external staging.
- Sits between the TB BRAM read port and the RSA A/M/extra operand inputs.

Parameters:
X, 4, lanes per destination port
L, 4, lanes in TB read word
RSA_DW, 32, bits per lane
NDST, 2, number of destination ports (0=A, 1=M, 2.. extra)
RD_LAT, 1, BRAM read latency in cycles (>=1)
WIN, 2, window width in lanes for the NEW map; must divide L and be <= X
DST_W, $clog2(NDST) (min 1), destination index width
OFS_W, $clog2(L/WIN) (min 1), window offset width

Ports:
clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
sel_vld  in  1  select valid, issued in the same cycle as the BRAM read address
sel_dst  in  DST_W  destination index
sel_dir  in  2  00 IDLE, 01 POS, 10 NEG, 11 NEW
sel_ofs  in  OFS_W  window index for NEW (replaces the single l_k_0 bit)
TB_douta  in  L*RSA_DW  BRAM read data, valid RD_LAT cycles after the address
dst_douta  out  NDST*X*RSA_DW  per-destination mapped data, registered
dst_vld  out  NDST  per-destination data valid, registered
map_err  out  1  sticky error flag

Behaviour:
- Reset (async assert, sync release): delay line cleared (all valid bits 0); dst_douta=0, dst_vld=0, map_err=0.
- Delay line: RD_LAT stages of {vld, dst, dir, ofs}, shifting every cycle. Stage RD_LAT-1 output is the aligned select, coincident with TB_douta.
- Output register, updated every cycle (total latency sel->dst_vld = RD_LAT+1):
  - Destination d == aligned dst with aligned vld=1 and dir != IDLE: dst_douta[d] <= map(TB_douta); dst_vld[d] <= 1.
  - All other destinations: dst_douta <= 0; dst_vld <= 0. Unselected ports are zero, never held, as the array relies on zero operands.
  - Aligned vld=1 with dir=IDLE: all destinations zero, dst_vld=0.
- Lane maps (out lane i, 0..X-1; any out-of-range source lane gives 0):
  - POS: out[i] = in[i] if i<L.
  - NEG: out[i] = in[X-1-i] if X-1-i<L.
  - NEW: out[i] = in[ofs*WIN+i] if i<WIN; else 0.
- Error conditions (data forced to zero, dst_vld=0, map_err set):
  - aligned dst >= NDST;
  - NEW with ofs >= L/WIN.
- map_err clears only on reset.
- Back-to-back selects are fully pipelined: one result per cycle, destination may change each cycle.
- Reset asserted mid-pipeline: in-flight selects are discarded and no output valid follows the reset release.
- Elaboration: if WIN does not divide L or WIN>X, stop elaboration via a generate-time error.

Optional Feature:
TB_ROUTER_HOLD_EN
- With macro: adds input port hold (1 bit). While hold=1, the delay line and output registers freeze (dst_vld keeps its value). The controller must also stall the BRAM so TB_douta stays stable. Releasing hold resumes with no lost or duplicated beats.
- Without macro: no hold port; the pipeline always advances.

Decomposition:
- Shared package: DIR_IDLE/DIR_POS/DIR_NEG/DIR_NEW encodings, destination index constants (DST_A=0, DST_M=1), and the select-bundle struct {vld,dst,dir,ofs}.
- One natural sub-module: tb_lane_map, the purely combinational L->X lane mapper parametrised by X, L, RSA_DW, WIN. The top contains the delay line, error logic and output registers.

Test Plan:
1. Reset, then sel_vld=1, dst=0, dir=POS, TB_douta lanes {3,2,1,0}=0x4,0x3,0x2,0x1 at RD_LAT=1 -> two cycles later dst_vld=01, A lanes 0..3 = 1,2,3,4, M=0.
2. dst=1, dir=NEG, same data -> M lanes 0..3 = 4,3,2,1, dst_vld=10, A=0.
3. dir=NEW, ofs=0 then ofs=1 back-to-back to dst=0 -> consecutive outputs {lanes0,1=1,2; lanes2,3=0} then {3,4,0,0}, one per cycle.
4. dir=NEW with ofs=2 (L=4, WIN=2) or dst=2 with NDST=2 -> outputs zero, dst_vld=0, map_err=1 and it stays 1 until reset.
5. Stream 4 POS selects; assert sys_rst_n=0 asynchronously mid-stream for 1 cycle -> outputs zero immediately; no dst_vld after release. Repeat with RD_LAT=3 to check latency 4.
6. With TB_ROUTER_HOLD_EN: hold=1 for 3 cycles mid-stream of 5 beats -> exactly 5 valid outputs, in order, values unchanged during hold.
